// File: rtl/ntt_bitrev_reorder.sv
// Output reorder stage after the NTT Montgomery multiplier: final modular
// correction, then two-bank ping-pong buffering that re-emits each frame in bit-reversed order.
module ntt_bitrev_reorder #(
    parameter int W       = 32,
    parameter int MODULUS = 7681,
    parameter int N       = 8,
    parameter int LOGN    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         out_last,
    output logic         frame_done,
    output logic         err_range
);

    localparam logic [W-1:0]    MOD  = W'(MODULUS);
    localparam logic [W:0]      MOD2 = (W+1)'(MODULUS) << 1;
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [1:0][N-1:0][W-1:0] bank;
    logic [1:0]               full, full_nxt;
    logic [LOGN-1:0]          wr_cnt, rd_cnt, rd_idx;
    logic                     wr_bank, rd_bank;
    logic                     wr_en, rd_en, wr_end, rd_end;
    logic [W-1:0]             wr_data;

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = rst && !full[wr_bank];
    assign wr_en     = in_valid && in_ready;
    assign wr_end    = wr_en && (wr_cnt == LAST);

    assign out_valid = rst && full[rd_bank];
    assign rd_en     = out_valid && out_ready;
    assign rd_end    = rd_en && (rd_cnt == LAST);
    assign out_data  = bank[rd_bank][rd_idx];
    assign out_last  = out_valid && (rd_cnt == LAST);

    always_comb begin
        rd_idx = '0;
        for (int i = 0; i < LOGN; i++) rd_idx[i] = rd_cnt[LOGN-1-i];
    end

    // single conditional subtraction; out-of-range inputs are flagged, not fixed
    always_comb begin
        wr_data = (in_data >= MOD) ? in_data - MOD : in_data;
    end

    // write and read always target different banks, so both updates can land together
    always_comb begin
        full_nxt = full;
        if (wr_end) full_nxt[wr_bank] = 1'b1;
        if (rd_end) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank       <= '0;
            full       <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
            err_range  <= 1'b0;
        end else begin
            full       <= full_nxt;
            frame_done <= rd_end;
            if (wr_en) begin
                bank[wr_bank][wr_cnt] <= wr_data;
                wr_cnt                <= wr_end ? '0 : wr_cnt + 1'b1;
                if ({1'b0, in_data} >= MOD2) err_range <= 1'b1;
                if (wr_end) wr_bank <= ~wr_bank;
            end
            if (rd_en) begin
                rd_cnt <= rd_end ? '0 : rd_cnt + 1'b1;
                if (rd_end) rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Directed bench for ntt_bitrev_reorder (N=8, MODULUS=7681): expected output
// orders and corrected values are written out by hand.
module tb_ntt_bitrev_reorder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        frame_done;
    logic        err_range;

    ntt_bitrev_reorder #(.W(32), .MODULUS(7681), .N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] inq[$];
    logic [32:0] expq[$];
    int          acc_cnt, bubbles, stalls, tick, acc_tick, first_ov_tick;
    bit          seen_out, last_prev;
    int          br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // frame of base..base+7 (all < MODULUS), expected in bit-reversed order
    task automatic push_plain(input int base);
        for (int i = 0; i < 8; i++) inq.push_back(32'(base + i));
        for (int j = 0; j < 8; j++) expq.push_back({j == 7, 32'(base + br[j])});
    endtask

    task automatic clear_stats();
        acc_cnt = 0; bubbles = 0; stalls = 0; seen_out = 0; first_ov_tick = -1;
    endtask

    task automatic run(input int max, input logic ordy, input bit must_finish);
        int c;
        logic [32:0] e;
        c = 0;
        while (c < max && (inq.size() > 0 || expq.size() > 0 || !must_finish || last_prev)) begin
            @(negedge clk);
            in_valid  = inq.size() > 0;
            in_data   = in_valid ? inq[0] : '0;
            out_ready = ordy;
            #1;
            tick++;
            chk("frame_done", {31'd0, frame_done}, {31'd0, last_prev});
            last_prev = 0;
            if (out_valid) begin
                if (!seen_out) first_ov_tick = tick;
                seen_out = 1;
            end else if (seen_out && expq.size() > 0) bubbles++;
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                void'(inq.pop_front());
                acc_cnt++;
                acc_tick = tick;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("extra_out", {31'd0, out_valid}, 32'd0);
                else begin
                    e = expq.pop_front();
                    chk("out_data", out_data, e[31:0]);
                    chk("out_last", {31'd0, out_last}, {31'd0, e[32]});
                    last_prev = out_last;
                end
            end else if (!out_valid) chk("last_idle", {31'd0, out_last}, 32'd0);
            c++;
        end
        in_valid = 1'b0;
        if (must_finish) chk("pending_after_budget", 32'(inq.size() + expq.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1;
        chk("rst_out_valid2", {31'd0, out_valid}, 32'd0);
        chk("rst_err_range", {31'd0, err_range}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        inq.delete(); expq.delete(); last_prev = 0;
    endtask

    initial begin
        tick = 0; acc_tick = 0; last_prev = 0;
        clear_stats();
        do_reset();

        // basic frame, minimum latency
        push_plain(100);
        run(100, 1'b1, 1'b1);
        chk("latency", 32'(first_ov_tick - acc_tick), 32'd1);

        // correction
        inq = '{7686, 7680, 0, 15361, 7681, 1, 2, 3};
        expq = '{{1'b0, 32'd5}, {1'b0, 32'd0}, {1'b0, 32'd0}, {1'b0, 32'd2},
                 {1'b0, 32'd7680}, {1'b0, 32'd1}, {1'b0, 32'd7680}, {1'b1, 32'd3}};
        run(100, 1'b1, 1'b1);
        chk("corr_err_range", {31'd0, err_range}, 32'd0);

        // range error: 20000 stored as 12319
        inq = '{20000, 10, 11, 12, 13, 14, 15, 16};
        expq = '{{1'b0, 32'd12319}, {1'b0, 32'd13}, {1'b0, 32'd11}, {1'b0, 32'd15},
                 {1'b0, 32'd10}, {1'b0, 32'd14}, {1'b0, 32'd12}, {1'b1, 32'd16}};
        run(100, 1'b1, 1'b1);
        chk("range_err_set", {31'd0, err_range}, 32'd1);

        // backpressure: both banks fill, then drain
        clear_stats();
        push_plain(200); push_plain(208); push_plain(216);
        run(30, 1'b0, 1'b0);
        chk("bp_accepts", 32'(acc_cnt), 32'd16);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_data", out_data, 32'd200);
        run(200, 1'b1, 1'b1);
        chk("bp_total_accepts", 32'(acc_cnt), 32'd24);
        chk("range_err_sticky", {31'd0, err_range}, 32'd1);

        // back-to-back frames at full rate
        clear_stats();
        push_plain(1000); push_plain(1008); push_plain(1016); push_plain(1024);
        run(200, 1'b1, 1'b1);
        chk("b2b_bubbles", 32'(bubbles), 32'd0);
        chk("b2b_in_stalls", 32'(stalls), 32'd0);

        // reset during a drain with a partial frame pending
        push_plain(400);
        for (int i = 0; i < 5; i++) inq.push_back(32'(500 + i));
        run(20, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        do_reset();
        run(10, 1'b1, 1'b0);
        chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
        push_plain(300);
        run(100, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_bitrev_reorder.md
Name: ntt_bitrev_reorder

Overview:
Output reorder stage directly downstream of the NTT datapath's Montgomery multiplier output (final_result).
- Accepts one coefficient per cycle in natural arrival order.
- Applies the final conditional modular correction.
- Re-emits each frame of N coefficients in bit-reversed index order over a valid/ready handshake.
- Ping-pong (two-bank) buffering lets one frame drain while the next fills.

Parameters:
W, 32, data width of coefficients
MODULUS, 7681, prime modulus for final correction; must be < 2^(W-1)
N, 8, frame length (transform size); power of two, >= 2
LOGN, $clog2(N), derived index width; not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (0 = reset)
in_valid  input  1  in_data holds a valid coefficient
in_data  input  W  coefficient from multiplier; range [0, 2*MODULUS)
in_ready  output  1  block can accept in_data this cycle
out_valid  output  1  out_data holds a valid reordered coefficient
out_data  output  W  coefficient, range [0, MODULUS)
out_ready  input  1  downstream accepts out_data this cycle
out_last  output  1  out_data is the final word of a frame
frame_done  output  1  one-cycle pulse after the last word of a frame is consumed
err_range  output  1  sticky: an accepted in_data was >= 2*MODULUS

Behaviour:
Reset (rst==0 at a clk edge):
- All bank full flags, wr_cnt, rd_cnt, wr_bank and rd_bank clear to 0.
- out_valid=0, out_last=0, frame_done=0, err_range=0, in_ready=0 while rst==0.
- Bank contents cleared to 0.
- A reset mid-frame discards all partial and complete frames; no output afterwards until a fresh N-word frame is written.

Storage:
- Two banks of N x W flops: bank0 and bank1.
- Per-bank full flag.

Write side:
- in_ready = rst && !full[wr_bank].
- Accept when in_valid && in_ready.
- Correction on accept: d = in_data; if d >= MODULUS then d = d - MODULUS (one subtraction, unsigned, W bits).
- If in_data >= 2*MODULUS: store in_data - MODULUS anyway and set err_range (sticky until reset).
- Store d at bank[wr_bank][wr_cnt]; wr_cnt increments.
- On accept with wr_cnt==N-1: wr_cnt wraps to 0, full[wr_bank] sets, wr_bank toggles (all at the same edge).

Read side:
- out_valid = full[rd_bank].
- out_data = bank[rd_bank][bitrev(rd_cnt)], read combinationally from flops. bitrev reverses the LOGN bits.
- out_last = out_valid && rd_cnt==N-1.
- Transfer when out_valid && out_ready; rd_cnt increments.
- On transfer with rd_cnt==N-1: rd_cnt wraps to 0, full[rd_bank] clears, rd_bank toggles, frame_done pulses high in the next cycle only.
- out_data and out_last must stay stable while out_valid && !out_ready.

Latency and boundaries:
- Minimum latency: last input word accepted at edge t gives out_valid=1 in the cycle after edge t. The first output word is bitrev(0)=index 0.
- Simultaneous last-read of one bank and last-write of the other in the same cycle: both flag updates take effect; no lost frame.
- Writes never target a full bank; reads never target an empty bank.
- Both banks full: in_ready=0 until the read side releases one bank. The release edge makes in_ready=1 the following cycle.
- Sustained throughput: 1 word/cycle with out_ready held high.
- No combinational path from out_ready to in_ready.
- FSM view per bank: EMPTY -> FILLING (first write) -> FULL (Nth write) -> DRAINING (first read) -> EMPTY (Nth read). Implemented via counters and full flags.

Test Plan:
- Reset then frame: after reset release, send 100..107 (N=8, out_ready=1) -> out_data 100,104,102,106,101,105,103,107; out_last only on 107; frame_done one cycle later.
- Correction: inputs 7686, 7680, 0, 15361, 7681, 1, 2, 3 -> corrected values 5, 7680, 0, 7680, 0, 1, 2, 3 emitted in bitrev order 5,7681→0,0,2,7680,1,7680,3. Check exactly 5,0,0,2,7680,1,7680,3 (corrected indices 0,4,2,6,1,5,3,7). err_range stays 0.
- Range error: one input 20000 -> err_range=1 and held through the frame until rst=0.
- Backpressure: out_ready=0, stream 24 words with in_valid=1 -> in_ready drops after exactly 16 accepts. Then raise out_ready -> 16 words out in correct order, and the remaining 8 accepted once a bank frees.
- Back-to-back: 4 consecutive frames, in_valid=out_ready=1 -> no bubbles after first frame latency; out_valid continuous.
- Reset mid-operation: rst=0 after 5 writes and during frame drain -> out_valid=0 next cycle; later a clean frame reorders correctly with no stale data.
